// File: rtl/exe_divider_pkg.sv
// Shared constants for the EXE-stage divider: FSM state codes, ready/stall
// encodings and the reset polarity used by the pipeline.
package exe_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_DONE   = 2'b11
  } div_state_t;

  localparam logic DIV_READY     = 1'b1;
  localparam logic DIV_NOT_READY = 1'b0;
  localparam logic STOP          = 1'b1;
  localparam logic NOSTOP        = 1'b0;
  localparam logic RST_ENABLE    = 1'b1;

endpackage

// File: rtl/exe_divider_if.sv
// Divider request/result bundle between the EXE stage (master) and the
// multi-cycle divider (slave), including the stall-control handshake.
interface exe_divider_if #(parameter int WIDTH = 32);
  logic             div_start;
  logic             div_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             div_cancel;
  logic             exe_stall;
  logic             stallreq_exe;
  logic             div_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output div_start, div_signed, dividend, divisor, div_cancel, exe_stall,
    input  stallreq_exe, div_ready, quotient, remainder
  );

  modport slave (
    input  div_start, div_signed, dividend, divisor, div_cancel, exe_stall,
    output stallreq_exe, div_ready, quotient, remainder
  );
endinterface

// File: rtl/exe_divider_step.sv
// One restoring shift-subtract iteration on magnitudes: brings the next
// dividend bit into the partial remainder and keeps the difference if non-negative.
module exe_divider_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Stored remainder is always below the divisor, so it fits WIDTH bits;
  // only the shifted trial value needs the extra bit.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  always_comb begin
    rem_out = diff[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], 1'b1};
    if (diff[WIDTH]) begin
      rem_out = shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/exe_divider.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EXE; requests a pipeline
// stall while busy and holds its result until the stall bus releases EXE.
module exe_divider
  import exe_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst,
  exe_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state, state_next;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] rem_reg, quo_reg, den_reg;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             neg_quo, neg_rem;
  logic             last_step;
  logic [WIDTH-1:0] dividend_abs, divisor_abs;

  assign dividend_abs = (bus.div_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign divisor_abs  = (bus.div_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
  assign last_step    = (counter == CNT_W'(WIDTH - 1));

  exe_divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .quo_in  (quo_reg),
    .divisor (den_reg),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  // Cancel masks the request in the same cycle the flush is seen.
  assign bus.stallreq_exe = (bus.div_start && !bus.div_cancel && state != DIV_DONE) ? STOP : NOSTOP;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst == RST_ENABLE) state <= DIV_IDLE;
    else                       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE:   if (bus.div_start) state_next = (bus.divisor == '0) ? DIV_BYZERO : DIV_ON;
      DIV_BYZERO: state_next = DIV_DONE;
      DIV_ON:     if (last_step) state_next = DIV_DONE;
      DIV_DONE:   if (!bus.exe_stall) state_next = DIV_IDLE;
      default:    state_next = DIV_IDLE;
    endcase
    if (bus.div_cancel) state_next = DIV_IDLE;
  end

  // For a zero divisor the raw dividend is parked in quo_reg and becomes the remainder.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst == RST_ENABLE) begin
      counter       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      den_reg       <= '0;
      neg_quo       <= 1'b0;
      neg_rem       <= 1'b0;
      bus.div_ready <= DIV_NOT_READY;
      bus.quotient  <= '0;
      bus.remainder <= '0;
    end else if (bus.div_cancel) begin
      counter       <= '0;
      bus.div_ready <= DIV_NOT_READY;
    end else begin
      case (state)
        DIV_IDLE: if (bus.div_start) begin
          counter <= '0;
          rem_reg <= '0;
          quo_reg <= (bus.divisor == '0) ? bus.dividend : dividend_abs;
          den_reg <= divisor_abs;
          neg_quo <= bus.div_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          neg_rem <= bus.div_signed && bus.dividend[WIDTH-1];
        end
        DIV_BYZERO: begin
          bus.quotient  <= '1;
          bus.remainder <= quo_reg;
          bus.div_ready <= DIV_READY;
        end
        DIV_ON: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          counter <= counter + 1'b1;
          if (last_step) begin
            bus.quotient  <= neg_quo ? -quo_step : quo_step;
            bus.remainder <= neg_rem ? -rem_step : rem_step;
            bus.div_ready <= DIV_READY;
          end
        end
        DIV_DONE: if (!bus.exe_stall) bus.div_ready <= DIV_NOT_READY;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_divider.sv
// Self-checking bench for exe_divider: directed vector table, randomized
// operations against an arithmetic reference, and stall/cancel/reset sequences.
module tb_exe_divider;

  localparam int WIDTH = 32;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  logic cpu_clk = 1'b0;
  logic cpu_rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_q, last_r;

  exe_divider_if #(.WIDTH(WIDTH)) bus();

  exe_divider #(.WIDTH(WIDTH)) dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain-arithmetic reference: 64-bit signed division truncates toward zero,
  // and the overflow case naturally wraps back to 0x80000000.
  function automatic void ref_model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Starts an operation and counts cycles until ready (cycle 0 = start cycle).
  task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                               output int lat, output int stalls);
    @(negedge cpu_clk);
    bus.div_start  = 1'b1;
    bus.div_signed = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    #1;
    lat    = -1;
    stalls = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.div_ready) begin
        lat = c;
        break;
      end
      if (bus.stallreq_exe) stalls++;
      @(negedge cpu_clk);
      #1;
    end
  endtask

  task automatic run_and_check(input string tag, input bit sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                               input int lat_exp);
    int lat, stalls;
    applyStimulus(sgn, a, b, lat, stalls);
    checkOutput({tag, " latency"}, 32'(lat), 32'(lat_exp));
    checkOutput({tag, " stall cycles"}, 32'(stalls), 32'(lat_exp));
    checkOutput({tag, " quotient"}, bus.quotient, q);
    checkOutput({tag, " remainder"}, bus.remainder, r);
    @(negedge cpu_clk);
    bus.div_start = 1'b0;
    #1;
    checkOutput({tag, " ready cleared"}, 32'(bus.div_ready), 32'd0);
    last_q = q;
    last_r = r;
  endtask

  initial begin
    vec_t        vecs[7];
    logic [31:0] a, b, q, r;
    bit          sgn;
    int          lat, stalls;

    vecs[0] = '{1'b0, 32'd100,        32'd7,         32'd14,        32'd2,         33};
    vecs[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 33};
    vecs[2] = '{1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         33};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         33};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 32'd0,         33};
    vecs[5] = '{1'b0, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF, 32'h0000_1234, 2};
    vecs[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};

    cpu_rst        = 1'b1;
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.div_cancel = 1'b0;
    bus.exe_stall  = 1'b0;
    repeat (2) @(negedge cpu_clk);
    cpu_rst = 1'b0;
    #1;
    checkOutput("reset ready", 32'(bus.div_ready), 32'd0);
    checkOutput("reset stallreq", 32'(bus.stallreq_exe), 32'd0);
    checkOutput("reset quotient", bus.quotient, 32'd0);
    checkOutput("reset remainder", bus.remainder, 32'd0);

    for (int i = 0; i < 7; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                    vecs[i].q, vecs[i].r, vecs[i].lat);

    // Result must be held in DONE while later stages stall, with no restart.
    bus.exe_stall = 1'b1;
    applyStimulus(1'b0, 32'd1000, 32'd9, lat, stalls);
    checkOutput("hold latency", 32'(lat), 32'd33);
    for (int k = 0; k < 5; k++) begin
      @(negedge cpu_clk);
      #1;
      checkOutput($sformatf("hold%0d ready", k), 32'(bus.div_ready), 32'd1);
      checkOutput($sformatf("hold%0d stallreq", k), 32'(bus.stallreq_exe), 32'd0);
      checkOutput($sformatf("hold%0d quotient", k), bus.quotient, 32'd111);
    end
    @(negedge cpu_clk);
    bus.exe_stall = 1'b0;
    @(negedge cpu_clk);
    bus.div_start = 1'b0;
    #1;
    checkOutput("hold release ready", 32'(bus.div_ready), 32'd0);
    last_q = 32'd111;

    // Flush in the middle of the iteration.
    @(negedge cpu_clk);
    bus.div_start  = 1'b1;
    bus.div_signed = 1'b0;
    bus.dividend   = 32'd5000;
    bus.divisor    = 32'd3;
    repeat (11) @(negedge cpu_clk);
    bus.div_cancel = 1'b1;
    #1;
    checkOutput("cancel stallreq", 32'(bus.stallreq_exe), 32'd0);
    @(negedge cpu_clk);
    bus.div_cancel = 1'b0;
    bus.div_start  = 1'b0;
    #1;
    checkOutput("cancel ready", 32'(bus.div_ready), 32'd0);
    checkOutput("cancel stallreq idle", 32'(bus.stallreq_exe), 32'd0);
    repeat (40) @(negedge cpu_clk);
    #1;
    checkOutput("cancel no result", 32'(bus.div_ready), 32'd0);
    checkOutput("cancel quotient kept", bus.quotient, last_q);

    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom % 2);
      a   = $urandom;
      case ($urandom % 4)
        0:       b = $urandom;
        1:       b = 32'($urandom % 16);
        2:       b = -32'($urandom % 16);
        default: b = $urandom >> ($urandom % 32);
      endcase
      ref_model(sgn, a, b, q, r);
      run_and_check($sformatf("rand%0d", i), sgn, a, b, q, r, (b == 0) ? 2 : 33);
    end

    // Reset in the middle of the iteration clears everything.
    @(negedge cpu_clk);
    bus.div_start  = 1'b1;
    bus.div_signed = 1'b1;
    bus.dividend   = 32'hFFFF_0000;
    bus.divisor    = 32'd5;
    repeat (15) @(negedge cpu_clk);
    cpu_rst = 1'b1;
    @(negedge cpu_clk);
    cpu_rst       = 1'b0;
    bus.div_start = 1'b0;
    #1;
    checkOutput("midrst ready", 32'(bus.div_ready), 32'd0);
    checkOutput("midrst stallreq", 32'(bus.stallreq_exe), 32'd0);
    checkOutput("midrst quotient", bus.quotient, 32'd0);
    checkOutput("midrst remainder", bus.remainder, 32'd0);
    repeat (40) @(negedge cpu_clk);
    #1;
    checkOutput("midrst no result", 32'(bus.div_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
